button_debouncer: RTL

- Per-bit debouncer and edge detector for the game's push-button inputs (paddle left/right, serve).
- Sits directly downstream of the two-flop input synchronizer and consumes its already-synchronized outputs.
- Produces clean level outputs plus single-cycle press/release pulses for the game-logic FSM.
- Sampling is gated by an external tick (e.g. 1 kHz or frame tick) so that counters stay narrow.

---
 rtl/button_debouncer_if.sv | 26 ++
 rtl/button_debouncer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer bus: sampled tick/raw levels in, clean level and edge pulses out.
interface button_debouncer_if #(
    parameter int WIDTH = 3
);
    logic             tick;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] released;

    modport master (
        output tick,
        output in,
        input  level,
        input  pressed,
        input  released
    );

    modport slave (
        input  tick,
        input  in,
        output level,
        output pressed,
        output released
    );
endinterface

// File: rtl/button_debouncer.sv
// Tick-gated per-bit debouncer with registered press/release pulses.
// Optional auto-repeat on held buttons: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer #(
    parameter int WIDTH         = 3,
    parameter int CNT_WIDTH     = 4,
    parameter int STABLE_COUNT  = 8,
    parameter bit DEFAULT_VALUE = 1'b0,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 6
) (
    input logic                clk,
    input logic                nRst,
    button_debouncer_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [WIDTH-1:0]     LEVEL_RST = {WIDTH{DEFAULT_VALUE}};

    generate
        if (STABLE_COUNT < 1 || STABLE_COUNT > (2 ** CNT_WIDTH) - 1) begin : g_bad_stable
            $error("button_debouncer: STABLE_COUNT out of range for CNT_WIDTH");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
            $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be positive");
        end
    endgenerate

    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]                level_q, level_d;
    logic [WIDTH-1:0]                pressed_q, pressed_d;
    logic [WIDTH-1:0]                released_q, released_d;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_WIDTH = $clog2(RMAX + 1);
    localparam logic [RCNT_WIDTH-1:0] R_DELAY  = RCNT_WIDTH'(REPEAT_DELAY);
    localparam logic [RCNT_WIDTH-1:0] R_PERIOD = RCNT_WIDTH'(REPEAT_PERIOD);

    // rfirst marks that the next repeat waits the long initial delay.
    logic [WIDTH-1:0][RCNT_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [WIDTH-1:0]                 rfirst_q, rfirst_d;

    always_comb begin
        cnt_d      = cnt_q;
        level_d    = level_q;
        pressed_d  = '0;
        released_d = '0;
        rcnt_d     = rcnt_q;
        rfirst_d   = rfirst_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!level_q[i]) begin
                rcnt_d[i]   = '0;
                rfirst_d[i] = 1'b1;
            end
            if (bus.tick) begin
                if (bus.in[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end else begin
                    cnt_d[i]      = '0;
                    level_d[i]    = bus.in[i];
                    pressed_d[i]  = bus.in[i];
                    released_d[i] = ~bus.in[i];
                end
                // A new level always restarts the repeat sequence from scratch.
                if (bus.in[i] != level_q[i] && cnt_q[i] == CNT_MAX) begin
                    rcnt_d[i]   = '0;
                    rfirst_d[i] = 1'b1;
                end else if (level_q[i]) begin
                    if ((rcnt_q[i] + RCNT_WIDTH'(1)) == (rfirst_q[i] ? R_DELAY : R_PERIOD)) begin
                        pressed_d[i] = 1'b1;
                        rcnt_d[i]    = '0;
                        rfirst_d[i]  = 1'b0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RCNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rcnt_q   <= '0;
            rfirst_q <= '1;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
        end
    end
`else
    always_comb begin
        cnt_d      = cnt_q;
        level_d    = level_q;
        pressed_d  = '0;
        released_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.tick) begin
                if (bus.in[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end else begin
                    cnt_d[i]      = '0;
                    level_d[i]    = bus.in[i];
                    pressed_d[i]  = bus.in[i];
                    released_d[i] = ~bus.in[i];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q      <= '0;
            level_q    <= LEVEL_RST;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.pressed  = pressed_q;
    assign bus.released = released_q;
endmodule
